sq_dist_accum: RTL
==================

SQ_DIST_ACCUM -- requirements
Module: sq_dist_accum

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as listed in REQ-002 to REQ-006.
REQ-002 VALUE_WIDTH, 12: signed input element width.
REQ-003 VALUE_MAX, 1500: clamp magnitude applied to every input element.
REQ-004 LANES, 2: elements processed per beat.
REQ-005 VECTOR_LEN, 8: elements per vector; must be a multiple of LANES, so BEATS = VECTOR_LEN/LANES.
REQ-006 ACC_WIDTH, 32: unsigned width of the distance result.
REQ-007 Ports (name, direction, width, meaning) SHALL be as listed in REQ-008 to REQ-015.
REQ-008 clk, in, 1: clock; all logic on rising edge.
REQ-009 reset, in, 1: reset; synchronous, active-low.
REQ-010 data_valid, in, 1: beat qualifier.
REQ-011 value_a, in, LANES*VALUE_WIDTH: signed elements, lane 0 in the LSBs.
REQ-012 value_b, in, LANES*VALUE_WIDTH: signed reference elements, same packing as value_a.
REQ-013 distance, out, ACC_WIDTH: sum over the vector of (a-b)^2.
REQ-014 new_result, out, 1: one-cycle pulse; distance is valid in that cycle.
REQ-015 saturated, out, 1: distance was clipped; valid with new_result.

Function
REQ-016 A beat is accepted on a rising edge where reset=1 and data_valid=1; beats with data_valid=0 are ignored, and gaps of any length between beats are allowed.
REQ-017 Each element is clamped to [-VALUE_MAX, +VALUE_MAX] before subtraction.
REQ-018 The difference is computed at VALUE_WIDTH+1 bits signed and squared to an unsigned 2*(VALUE_WIDTH+1)-bit result; no intermediate truncation is allowed.
REQ-019 Pipeline stages, with the beat sampled at edge k:
- edge k: difference registered;
- edge k+1: square registered;
- edge k+2: lane sum registered;
- edge k+3: accumulator/result registered.
REQ-020 A valid bit travels with each stage, so bubbles never corrupt the accumulator.
REQ-021 A beat counter counts accepted beats 0..BEATS-1 and wraps to 0 after beat BEATS-1; that beat is tagged "last".
REQ-022 The accumulator loads (rather than adds) on a stage-4 beat tagged "first", so back-to-back vectors need no idle cycle.
REQ-023 When the stage-4 beat is tagged "last", the edge k+3 registers distance and saturated, and new_result is 1 for exactly the following cycle.
REQ-024 Latency from the last-beat sample edge to the new_result cycle is 3 clocks; throughput is one beat per clock.
REQ-025 distance and saturated SHALL hold their value until the next result.
REQ-026 If the true sum exceeds 2^ACC_WIDTH-1, the accumulator sticks at 2^ACC_WIDTH-1 and saturated=1 for that vector; the flag clears at the next vector's first beat.
REQ-027 BEATS=1 is legal: every accepted beat is both first and last.

Reset
REQ-028 While reset=0, at every edge the beat counter, all pipeline valid bits, the accumulator, distance, saturated and new_result SHALL go to 0.
REQ-029 A reset mid-vector discards the partial vector; no new_result is produced for it.
REQ-030 The first beat accepted after reset is beat 0 of a new vector.
REQ-031 Pipeline data registers need no reset; only valid bits and outputs are reset.

Structure
REQ-032 The shared package/include SHALL hold VALUE_WIDTH, VALUE_MAX, LANES and VECTOR_LEN defaults, plus a function giving the minimum lossless ACC_WIDTH.
REQ-033 The per-lane clamp, subtract and square path is one sub-module, sq_lane, instantiated LANES times via generate.
REQ-034 The top level holds the lane adder, beat counter, tag pipeline and accumulator.

Verification (LANES=2, VECTOR_LEN=4, VALUE_WIDTH=12, VALUE_MAX=1500)
REQ-035 Basic: beat a={3,-4}, b={0,0}, then beat a={0,0}, b={0,0} -> distance=25, new_result 3 clocks after the second beat.
REQ-036 Extremes: both beats a={1500,1500}, b={-1500,-1500} -> distance=36000000, saturated=0.
REQ-037 Clamp: a={2000,-2047}, b={0,0}, then zeros -> distance=4500000.
REQ-038 Gaps and back-to-back: 3 idle cycles between beats, then a second vector immediately after -> the same distances as without gaps, and two single-cycle pulses.
REQ-039 Saturation: ACC_WIDTH=25 with the extremes vector -> distance=33554431, saturated=1; the next zero vector -> 0, saturated=0.
REQ-040 Reset mid-vector: one beat, then reset=0 for 1 cycle, then a full vector a={1,1}, {1,1}, b=0 -> only one new_result, distance=4.

Source files
------------

// File: rtl/sq_dist_accum_pkg.sv
// Shared defaults and helpers for the squared-distance accumulator.
package sq_dist_accum_pkg;

  localparam int VALUE_WIDTH_DEF = 12;
  localparam int VALUE_MAX_DEF   = 1500;
  localparam int LANES_DEF       = 2;
  localparam int VECTOR_LEN_DEF  = 8;

  // Tag carried alongside each beat through the pipeline.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_tag_t;

  // Smallest accumulator width that can hold the worst-case vector sum
  // without clipping: VECTOR_LEN * (2*VALUE_MAX)^2.
  function automatic int min_acc_width(input int value_max, input int vector_len);
    longint unsigned worst;
    int              w;
    worst = longint'(2 * value_max) * longint'(2 * value_max) * longint'(vector_len);
    w = 1;
    for (int i = 0; i < 64; i++) begin
      if ((worst >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sq_dist_accum_lane.sv
// One lane: clamp both elements, subtract at full width, square.
// Data registers only; the valid/tag pipeline lives in the top level.
module sq_lane #(
  parameter int VALUE_WIDTH = 12,
  parameter int VALUE_MAX   = 1500
) (
  input  logic                           clk,
  input  logic signed [VALUE_WIDTH-1:0]  a_i,
  input  logic signed [VALUE_WIDTH-1:0]  b_i,
  output logic [2*(VALUE_WIDTH+1)-1:0]   sq_o
);

  localparam int DW = VALUE_WIDTH + 1;
  localparam int SW = 2 * DW;

  localparam logic signed [DW-1:0] MAX_POS = DW'(VALUE_MAX);
  localparam logic signed [DW-1:0] MAX_NEG = DW'(-VALUE_MAX);

  logic signed [DW-1:0] a_clamped;
  logic signed [DW-1:0] b_clamped;
  logic signed [DW-1:0] diff_d;
  logic signed [DW-1:0] diff_q;
  logic signed [SW-1:0] diff_ext;
  logic        [SW-1:0] sq_d;
  logic        [SW-1:0] sq_q;

  function automatic logic signed [DW-1:0] clamp(input logic signed [VALUE_WIDTH-1:0] v);
    logic signed [DW-1:0] x;
    x = {v[VALUE_WIDTH-1], v};
    if (x > MAX_POS)      return MAX_POS;
    else if (x < MAX_NEG) return MAX_NEG;
    else                  return x;
  endfunction

  // Clamp and subtract; the extra bit keeps the difference exact.
  always_comb begin
    a_clamped = clamp(a_i);
    b_clamped = clamp(b_i);
    diff_d    = a_clamped - b_clamped;
  end

  // Square at double width so nothing is truncated.
  always_comb begin
    diff_ext = {{DW{diff_q[DW-1]}}, diff_q};
    sq_d     = diff_ext * diff_ext;
  end

  // Stage 1 (difference) and stage 2 (square) data registers.
  always_ff @(posedge clk) begin
    diff_q <= diff_d;
    sq_q   <= sq_d;
  end

  assign sq_o = sq_q;

endmodule

// File: rtl/sq_dist_accum.sv
// Streaming squared Euclidean distance over fixed-length vectors.
// Four-stage pipeline: difference, square, lane sum, accumulate.
module sq_dist_accum
  import sq_dist_accum_pkg::*;
#(
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEF,
  parameter int VALUE_MAX   = VALUE_MAX_DEF,
  parameter int LANES       = LANES_DEF,
  parameter int VECTOR_LEN  = VECTOR_LEN_DEF,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           data_valid,
  input  logic [LANES*VALUE_WIDTH-1:0]   value_a,
  input  logic [LANES*VALUE_WIDTH-1:0]   value_b,
  output logic [ACC_WIDTH-1:0]           distance,
  output logic                           new_result,
  output logic                           saturated
);

  localparam int BEATS = VECTOR_LEN / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SQ_W  = 2 * (VALUE_WIDTH + 1);
  localparam int SUM_W = SQ_W + ((LANES > 1) ? $clog2(LANES) : 0);
  localparam int EXT_W = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;

  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX   = '1;

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             beat_first, beat_last;
  beat_tag_t        tag1_q, tag2_q, tag3_q;

  logic [SQ_W-1:0]  lane_sq [LANES];
  logic [SUM_W-1:0] lane_sum_d, lane_sum_q;

  logic [EXT_W-1:0]     acc_base, acc_total;
  logic                 overflow;
  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                 sat_d, sat_q;
  logic [ACC_WIDTH-1:0] distance_q;
  logic                 saturated_q;
  logic                 new_result_q;

  // Per-lane clamp / subtract / square.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      sq_lane #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .VALUE_MAX   (VALUE_MAX)
      ) u_lane (
        .clk  (clk),
        .a_i  (value_a[gi*VALUE_WIDTH +: VALUE_WIDTH]),
        .b_i  (value_b[gi*VALUE_WIDTH +: VALUE_WIDTH]),
        .sq_o (lane_sq[gi])
      );
    end
  endgenerate

  // Beat position within the vector; wraps after the last beat.
  always_comb begin
    beat_first = (beat_cnt_q == '0);
    beat_last  = (beat_cnt_q == LAST_BEAT);
    beat_cnt_d = beat_cnt_q;
    if (data_valid) begin
      beat_cnt_d = beat_last ? '0 : beat_cnt_q + 1'b1;
    end
  end

  // Beat counter and tag pipeline; reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_cnt_q <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      tag3_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      tag1_q     <= '{valid: data_valid, first: beat_first, last: beat_last};
      tag2_q     <= tag1_q;
      tag3_q     <= tag2_q;
    end
  end

  // Sum of all lane squares for the beat.
  always_comb begin
    lane_sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum_d = lane_sum_d + SUM_W'(lane_sq[i]);
    end
  end

  // Stage 3 data register.
  always_ff @(posedge clk) begin
    lane_sum_q <= lane_sum_d;
  end

  // Accumulate (or load on a first beat) with sticky saturation.
  always_comb begin
    acc_base  = tag3_q.first ? '0 : EXT_W'(acc_q);
    acc_total = acc_base + EXT_W'(lane_sum_q);
    overflow  = |acc_total[EXT_W-1:ACC_WIDTH];
    acc_d     = overflow ? ACC_MAX : acc_total[ACC_WIDTH-1:0];
    sat_d     = overflow | (~tag3_q.first & sat_q);
  end

  // Stage 4: accumulator and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q        <= '0;
      sat_q        <= 1'b0;
      distance_q   <= '0;
      saturated_q  <= 1'b0;
      new_result_q <= 1'b0;
    end else begin
      new_result_q <= tag3_q.valid & tag3_q.last;
      if (tag3_q.valid) begin
        acc_q <= acc_d;
        sat_q <= sat_d;
        if (tag3_q.last) begin
          distance_q  <= acc_d;
          saturated_q <= sat_d;
        end
      end
    end
  end

  assign distance   = distance_q;
  assign saturated  = saturated_q;
  assign new_result = new_result_q;

endmodule
